// File: rtl/khani_sort_seq.sv
// rtl/khani_sort_seq.sv - frame sequencer around an external combinational N-word ascending sorter
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   in_valid      upstream word valid
//   in_ready      block accepts a word (LOAD only)
//   in_data       upstream word
//   in_last       final word of the upstream frame
//   sorter_in     load buffer, word i at [i*WIDTH +: WIDTH], to the external sorter
//   sorter_out    ascending result from the external sorter, word 0 smallest
//   out_valid     sorted word valid (DRAIN only)
//   out_ready     downstream accepts
//   out_data      sorted word
//   out_last      final word of the output frame
//   busy          high unless idle in LOAD with an empty buffer
//   trunc         pulse when the Nth word is accepted without in_last

module khani_sort_seq #(
    parameter int              N     = 6,
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] PAD  = '1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic [N*WIDTH-1:0]   sorter_in,
    input  logic [N*WIDTH-1:0]   sorter_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 trunc
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
    localparam logic [CW-1:0] N_CW     = CW'(N);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    len_q;
    logic [CW-1:0]    rd_idx_q;
    logic [WIDTH-1:0] load_buf [N];
    logic [WIDTH-1:0] result_q [N];
    logic             accept;
    logic             frame_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        trunc     = 1'b0;
        accept    = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    frame_end = in_last || (count_q == LAST_IDX);
                    // A full buffer closes the frame even without in_last.
                    trunc     = !in_last && (count_q == LAST_IDX) && !rst;
                    if (frame_end) begin
                        state_d = SORT;
                    end
                end
            end
            SORT: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = (rd_idx_q == len_q - 1'b1);
                if (out_ready && out_last) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            len_q    <= '0;
            rd_idx_q <= '0;
            for (int i = 0; i < N; i++) begin
                load_buf[i] <= PAD;
                result_q[i] <= '0;
            end
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        load_buf[count_q] <= in_data;
                        count_q           <= count_q + 1'b1;
                        if (frame_end) begin
                            len_q <= count_q + 1'b1;
                        end
                    end
                end
                SORT: begin
                    // Unused slots were PAD, so they sort above every real word.
                    for (int i = 0; i < N; i++) begin
                        result_q[i] <= sorter_out[i*WIDTH +: WIDTH];
                        load_buf[i] <= PAD;
                    end
                    count_q  <= '0;
                    rd_idx_q <= '0;
                end
                DRAIN: begin
                    if (out_ready) begin
                        rd_idx_q <= rd_idx_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        sorter_in = '0;
        for (int i = 0; i < N; i++) begin
            sorter_in[i*WIDTH +: WIDTH] = load_buf[i];
        end
    end

    // rd_idx steps to len after the final beat; keep that index off the array.
    assign out_data = (rd_idx_q < N_CW) ? result_q[rd_idx_q] : '0;
    assign busy     = (state_q != LOAD) || (count_q != '0);

endmodule

// File: tb/tb_khani_sort_seq.sv
// tb/tb_khani_sort_seq.sv - directed self-checking bench for khani_sort_seq

module tb_khani_sort_seq;

    localparam int N = 6;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_data = '0;
    logic           in_last = 1'b0;
    logic [N*W-1:0] sorter_in;
    logic [N*W-1:0] sorter_out;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           busy;
    logic           trunc;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] in_a  [8];
    logic [W-1:0] exp_a [8];

    always #5 clk = ~clk;

    khani_sort_seq #(.N(N), .WIDTH(W), .PAD(8'hFF)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .sorter_in  (sorter_in),
        .sorter_out (sorter_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .trunc      (trunc)
    );

    // Behavioural stand-in for the external combinational sorter.
    function automatic logic [N*W-1:0] sort_vec(input logic [N*W-1:0] v);
        logic [W-1:0] a [N];
        logic [W-1:0] t;
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) a[i] = v[i*W +: W];
        for (int i = 0; i < N - 1; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = a[i];
        return r;
    endfunction

    assign sorter_out = sort_vec(sorter_in);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"},  32'(in_ready),  1);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 0);
        check_eq({tag, "_out_last"},  32'(out_last),  0);
        check_eq({tag, "_out_data"},  32'(out_data),  0);
        check_eq({tag, "_busy"},      32'(busy),      0);
        check_eq({tag, "_trunc"},     32'(trunc),     0);
    endtask

    // Drives in_a[0..n-1] back to back; in_last on the final word if last.
    task automatic send_frame(input int n, input bit last);
        int wait_n;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = in_a[i];
            in_last  = last && (i == n - 1);
            #1;
            wait_n = 0;
            while (!in_ready && wait_n < 50) begin
                @(negedge clk); #1;
                wait_n++;
            end
            if (!in_ready) check_eq("in_ready_timeout", 0, 1);
            check_eq("trunc", 32'(trunc), 32'((i == N - 1) && !last));
            @(posedge clk);
        end
    endtask

    // Called right after the closing accept: one SORT cycle, then DRAIN.
    task automatic post_last_check();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        check_eq("sort_in_ready",  32'(in_ready),  0);
        check_eq("sort_out_valid", 32'(out_valid), 0);
        @(negedge clk); #1;
        check_eq("latency_valid",  32'(out_valid), 1);
    endtask

    task automatic collect(input int n, input bit bp);
        int k = 0;
        int c = 0;
        bit done = 0;
        bit stall_prev = 0;
        logic [W-1:0] d_prev = '0;
        logic l_prev = 1'b0;
        while (!done && c < 200) begin
            out_ready = bp ? (c % 3 == 0) : 1'b1;
            #1;
            if (out_valid) begin
                check_eq("drain_in_ready", 32'(in_ready), 0);
                if (stall_prev) begin
                    check_eq("hold_data", 32'(out_data), 32'(d_prev));
                    check_eq("hold_last", 32'(out_last), 32'(l_prev));
                end
                if (out_ready) begin
                    if (k < 8) check_eq("data", 32'(out_data), 32'(exp_a[k]));
                    check_eq("last", 32'(out_last), 32'(k == n - 1));
                    if (out_last) done = 1;
                    k++;
                    stall_prev = 0;
                end else begin
                    stall_prev = 1;
                    d_prev = out_data;
                    l_prev = out_last;
                end
            end
            c++;
            @(posedge clk);
            @(negedge clk);
        end
        if (!done) check_eq("drain_timeout", 0, 1);
        out_ready = 1'b0;
        #1;
        check_eq("valid_drop", 32'(out_valid), 0);
        check_eq("beats", 32'(k), 32'(n));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst0");

        // Full frame, in_last on the 6th word.
        in_a  = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd0, 8'd0};
        exp_a = '{8'd1, 8'd1, 8'd3, 8'd4, 8'd5, 8'd9, 8'd0, 8'd0};
        send_frame(6, 1);
        post_last_check();
        collect(6, 0);

        // Short frame: PAD slots must never be emitted.
        in_a  = '{8'd7, 8'd2, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        exp_a = '{8'd2, 8'd7, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_frame(3, 1);
        post_last_check();
        collect(3, 0);

        // Real PAD-valued words.
        in_a  = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        exp_a = '{8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_frame(3, 1);
        post_last_check();
        collect(3, 0);

        // Backpressure 1,0,0 repeating.
        in_a  = '{8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
        exp_a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd0, 8'd0};
        send_frame(6, 1);
        post_last_check();
        collect(6, 1);

        // Truncation: 6 words without in_last close the frame.
        in_a  = '{8'd15, 8'd13, 8'd11, 8'd10, 8'd12, 8'd14, 8'd0, 8'd0};
        exp_a = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd0, 8'd0};
        send_frame(6, 0);
        post_last_check();
        collect(6, 0);
        in_a  = '{8'd16, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        exp_a = '{8'd16, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_frame(1, 1);
        post_last_check();
        collect(1, 0);

        // Reset mid-frame discards the partial frame.
        in_a  = '{8'd50, 8'd60, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_frame(2, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_eq("busy_mid_frame", 32'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst1");
        in_a  = '{8'd8, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        exp_a = '{8'd4, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_frame(2, 1);
        post_last_check();
        collect(2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d want=0", $time);
        $fatal(1);
    end

endmodule

// File: doc/khani_sort_seq.md
Name: khani_sort_seq

Overview:
- Sequencer that wraps the team's combinational N-input ascending sorter with a streaming interface.
- Collects a frame of up to N words from an upstream valid/ready stream into a load buffer.
- Presents the buffer to an external sorter instance and captures the sorted vector in one cycle.
- Replays the captured result downstream one word per beat with backpressure, so the sorter becomes a single-clock, frame-based pipeline stage.

Parameters:
- N, 6, frame capacity and sorter width in words (N >= 2)
- WIDTH, 8, bits per data word
- PAD, all-ones of WIDTH, fill value for unused slots of a short frame

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  block accepts a word this cycle
- in_data  in  WIDTH  upstream word
- in_last  in  1  final word of frame
- sorter_in  out  N x WIDTH  load buffer driven to the external sorter inputs
- sorter_out  in  N x WIDTH  combinational ascending result from the external sorter
- out_valid  out  1  sorted word valid
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  sorted word
- out_last  out  1  final word of the output frame
- busy  out  1  high in any state other than LOAD with count = 0
- trunc  out  1  one-cycle pulse: Nth word accepted without in_last

Behaviour:
- Reset is synchronous and active-high on clk and wins over every other event.
  - Reset state: LOAD.
  - in_ready = 1; out_valid = 0; out_last = 0; out_data = 0; busy = 0; trunc = 0.
  - count = 0; rd_idx = 0; load buffer = all PAD; result register = 0.
  - Reset mid-frame discards all buffered and undelivered data with no output.
- FSM has three states: LOAD, SORT, DRAIN.
- LOAD:
  - in_ready = 1.
  - On in_valid & in_ready, write in_data to buf[count] and increment count.
  - If in_last, or count was N-1 before the write, store len = count+1 and go to SORT.
  - If count reached N without in_last, pulse trunc for that cycle. Later words of the same upstream frame are treated as a new frame; upstream owns that error.
- SORT:
  - Lasts exactly 1 cycle; in_ready = 0.
  - Capture sorter_out into the result register.
  - Clear buf to PAD and set count = 0, rd_idx = 0, then go to DRAIN.
  - sorter_in is a direct view of buf. The sorter must settle within one clock period; it has no handshake.
- DRAIN:
  - out_valid = 1; out_data = result[rd_idx]; out_last = (rd_idx == len-1).
  - On out_valid & out_ready, increment rd_idx.
  - When the beat carrying out_last is accepted, go to LOAD; out_valid drops the next cycle.
  - While out_ready is low, out_data and out_last hold stable.
- Short frames: slots len..N-1 hold PAD, which sorts to the top. Only the first len sorted words are emitted. A frame containing real PAD-valued words is still correct because equal values are interchangeable.
- Latency:
  - From acceptance of the last input beat to first out_valid: 2 cycles (SORT, then DRAIN registered).
  - Throughput: len + len + 1 cycles per frame under no backpressure. Input and output are not overlapped.
- Simultaneous in_last with count = N-1 is a normal full frame, with no trunc.
- in_valid while in_ready = 0 is ignored; upstream must hold the word.
- len and rd_idx use clog2(N+1) bits; no wrap-around is reachable.

Test Plan:
- N=6, W=8. Feed 3,1,4,1,5,9 with in_last on the 6th beat and out_ready held high.
  - Required output: 1,1,3,4,5,9, with out_last on the 9.
  - First out_valid exactly 2 cycles after the 6th accept; trunc never pulses.
- Short frame 7,2,200 with in_last on the 3rd beat.
  - Required output: 2,7,200, with out_last on the 200; exactly 3 beats; no PAD (255) emitted.
- Frame 255,0,255 (PAD-valued data) with in_last on the 3rd beat.
  - Required output: 0,255,255, 3 beats.
- Backpressure: frame 6,5,4,3,2,1 with out_ready toggling 1,0,0,1,...
  - Required output: 1..6 in order; out_data stable while stalled.
  - in_ready = 0 throughout SORT and DRAIN.
- Truncation: 7 words 10..16 with no in_last.
  - trunc pulses on the 6th accept; output is 10..15.
  - Then 16 with in_last forms the next 1-word frame, output 16.
- Reset: assert rst after 2 words, then feed 8,4 with in_last.
  - Required output: 4,8 only; every output is at its reset value in the cycle after rst.
